matrix_multiply_seq: RTL and testbench

- Sequential controller and datapath that computes C = A*B with one shared multiply-accumulate unit instead of N^3 parallel multipliers.
- Captures the operand matrices on start and walks the (x, y, z) index space one product per cycle.
- Writes each finished C element into a result register bank and signals completion.
- Area-saving drop-in for the combinational matrix multiplier in the signal-processing chain, where matrix updates are infrequent.

---
 rtl/matrix_multiply_seq_pkg.sv | 33 +++
 rtl/matrix_multiply_seq_if.sv | 20 ++
 rtl/matrix_multiply_seq_mac.sv | 36 +++
 rtl/matrix_multiply_seq.sv | 123 ++++++++++++
 tb/tb_matrix_multiply_seq.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_multiply_seq_pkg.sv
// Shared types and sizing for the sequential matrix multiplier.
// Build option: MATMUL_SEQ_SATURATE_EN widens the accumulator and clamps
// each C element to the largest WORD_LENGTH-bit value instead of wrapping.
package matmul_pkg;

  localparam int DEF_MATRIX_SIZE = 3;
  localparam int DEF_WORD_LENGTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  // Index counter width; a 1x1 matrix still needs a one-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: the full dot-product range when saturating,
  // otherwise the element width so that every step wraps.
  function automatic int acc_width(input int n, input int w);
`ifdef MATMUL_SEQ_SATURATE_EN
    return 2 * w + $clog2(n);
`else
    return w;
`endif
  endfunction

  localparam int IDX_W = idx_width(DEF_MATRIX_SIZE);
  localparam int ACC_W = acc_width(DEF_MATRIX_SIZE, DEF_WORD_LENGTH);

endpackage

// File: rtl/matrix_multiply_seq_if.sv
// Operand/result bundle between a requester and the sequential multiplier.
// Build option MATMUL_SEQ_SATURATE_EN does not change this interface.
interface matrix_multiply_seq_if
  import matmul_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int WORD_LENGTH = DEF_WORD_LENGTH
);

  logic                   start;
  logic [WORD_LENGTH-1:0] A [MATRIX_SIZE][MATRIX_SIZE];
  logic [WORD_LENGTH-1:0] B [MATRIX_SIZE][MATRIX_SIZE];
  logic [WORD_LENGTH-1:0] C [MATRIX_SIZE][MATRIX_SIZE];
  logic                   busy;
  logic                   done;

  modport master (output start, A, B, input C, busy, done);
  modport slave  (input start, A, B, output C, busy, done);

endinterface

// File: rtl/matrix_multiply_seq_mac.sv
// Single multiply-accumulate step with the C-element reduction.
// Build option MATMUL_SEQ_SATURATE_EN: full-width product and accumulator,
// result clamped to the element range; otherwise everything wraps modulo
// 2^WORD_LENGTH.
module matmul_mac #(
  parameter int WORD_LENGTH = 8,
  parameter int ACC_W       = 8
) (
  input  logic [WORD_LENGTH-1:0] a_i,
  input  logic [WORD_LENGTH-1:0] b_i,
  input  logic [ACC_W-1:0]       acc_i,
  input  logic                   clear_i,
  output logic [ACC_W-1:0]       acc_o,
  output logic [WORD_LENGTH-1:0] res_o
);

  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] prod;

  assign base = clear_i ? '0 : acc_i;

`ifdef MATMUL_SEQ_SATURATE_EN
  localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'({WORD_LENGTH{1'b1}});

  assign prod  = ACC_W'(a_i) * ACC_W'(b_i);
  assign acc_o = base + prod;
  assign res_o = (acc_o > MAX_VAL) ? {WORD_LENGTH{1'b1}} : acc_o[WORD_LENGTH-1:0];
`else
  // Product truncated to the accumulator width, matching the combinational
  // multiplier's modulo behaviour.
  assign prod  = a_i * b_i;
  assign acc_o = base + prod;
  assign res_o = acc_o;
`endif

endmodule

// File: rtl/matrix_multiply_seq.sv
// Sequential C = A*B using one shared MAC, one product per clock.
// Build option MATMUL_SEQ_SATURATE_EN selects saturating results (see matmul_mac).
module matrix_multiply_seq
  import matmul_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int WORD_LENGTH = DEF_WORD_LENGTH
) (
  input logic                  clk,
  input logic                  reset,
  matrix_multiply_seq_if.slave bus
);

  localparam int IW = idx_width(MATRIX_SIZE);
  localparam int AW = acc_width(MATRIX_SIZE, WORD_LENGTH);
  localparam logic [IW-1:0] LAST = IW'(MATRIX_SIZE - 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          x_q, x_d, y_q, y_d, z_q, z_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [WORD_LENGTH-1:0] a_q [MATRIX_SIZE][MATRIX_SIZE];
  logic [WORD_LENGTH-1:0] b_q [MATRIX_SIZE][MATRIX_SIZE];
  logic [WORD_LENGTH-1:0] c_q [MATRIX_SIZE][MATRIX_SIZE];
  logic                   capture;
  logic                   c_wr;
  logic [AW-1:0]          mac_acc;
  logic [WORD_LENGTH-1:0] mac_res;

  matmul_mac #(
    .WORD_LENGTH (WORD_LENGTH),
    .ACC_W       (AW)
  ) u_mac (
    .a_i     (a_q[x_q][z_q]),
    .b_i     (b_q[z_q][y_q]),
    .acc_i   (acc_q),
    .clear_i (z_q == '0),
    .acc_o   (mac_acc),
    .res_o   (mac_res)
  );

  // Next state, index walk and write strobes for the current MAC step.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    acc_d   = acc_q;
    capture = 1'b0;
    c_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          x_d     = '0;
          y_d     = '0;
          z_d     = '0;
          acc_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (z_q != LAST) begin
          acc_d = mac_acc;
          z_d   = z_q + IW'(1);
        end else begin
          c_wr  = 1'b1;
          acc_d = '0;
          z_d   = '0;
          if (y_q != LAST) begin
            y_d = y_q + IW'(1);
          end else begin
            y_d = '0;
            if (x_q != LAST) begin
              x_d = x_q + IW'(1);
            end else begin
              x_d     = '0;
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller state, counters, accumulator and result bank.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      acc_q   <= '0;
      for (int i = 0; i < MATRIX_SIZE; i++)
        for (int j = 0; j < MATRIX_SIZE; j++)
          c_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      acc_q   <= acc_d;
      if (c_wr) c_q[x_q][y_q] <= mac_res;
    end
  end

  // Operand capture on the start-accepting edge.
  // NOTE: the operand copies are not reset; they are always loaded before the first read.
  always_ff @(posedge clk) begin
    if (capture) begin
      a_q <= bus.A;
      b_q <= bus.B;
    end
  end

  assign bus.C    = c_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_matrix_multiply_seq.sv
// Self-checking bench for matrix_multiply_seq (3x3, 8-bit elements).
// Honours MATMUL_SEQ_SATURATE_EN in its reference model.
module tb_matrix_multiply_seq;

  localparam int N = 3;

  typedef logic [7:0] mat_t [N][N];

  logic clk = 1'b0;
  logic reset;

  int vectors = 0;
  int errors  = 0;

  matrix_multiply_seq_if #(.MATRIX_SIZE(N), .WORD_LENGTH(8)) bus_if ();

  matrix_multiply_seq #(.MATRIX_SIZE(N), .WORD_LENGTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference: exact integer dot products, reduced once at the end.
  // Modulo reduction at the end equals reduction at every step.
  function automatic mat_t model(input mat_t a, input mat_t b);
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(a[i][k]) * int'(b[k][j]);
`ifdef MATMUL_SEQ_SATURATE_EN
        r[i][j] = (s > 255) ? 8'hFF : 8'(s);
`else
        r[i][j] = 8'(s % 256);
`endif
      end
    return r;
  endfunction

  function automatic mat_t fill(input int v);
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = 8'(v);
    return r;
  endfunction

  function automatic mat_t seq1(input int first);
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = 8'(first + i * N + j);
    return r;
  endfunction

  function automatic mat_t rnd();
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // Start a run; report edges to done, busy-high cycles and C at done.
  task automatic do_run(input mat_t a, input mat_t b,
                        output int lat, output int busy_cnt, output mat_t c_seen);
    @(negedge clk);
    bus_if.A     = a;
    bus_if.B     = b;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (bus_if.done !== 1'b1 && lat < 100) begin
      if (bus_if.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (bus_if.busy === 1'b1) busy_cnt++;
    c_seen = bus_if.C;
    @(negedge clk);
    if (bus_if.busy === 1'b1) busy_cnt++;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus_if.start = 1'b0;
    bus_if.A     = fill(0);
    bus_if.B     = fill(0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vectors++;
        if (bus_if.C[i][j] !== 8'd0) begin
          errors++;
          $display("FAIL reset_C[%0d][%0d] got %0d want 0", i, j, bus_if.C[i][j]);
        end
      end
  endtask

  task automatic test_product(input string name, input mat_t a, input mat_t b);
    int   lat, bc;
    mat_t got, exp_c;
    exp_c = model(a, b);
    do_run(a, b, lat, bc, got);
    vectors++;
    if (lat !== 27) begin
      errors++;
      $display("FAIL %s_latency got %0d want 27", name, lat);
    end
    vectors++;
    if (bc !== 28) begin
      errors++;
      $display("FAIL %s_busy_cycles got %0d want 28", name, bc);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vectors++;
        if (got[i][j] !== exp_c[i][j]) begin
          errors++;
          $display("FAIL %s_C[%0d][%0d] got %0d want %0d", name, i, j, got[i][j], exp_c[i][j]);
        end
      end
  endtask

  task automatic test_identity();
    mat_t id;
    id = fill(0);
    for (int i = 0; i < N; i++) id[i][i] = 8'd1;
    test_product("identity", id, seq1(1));
  endtask

  task automatic test_general();
    test_product("general", seq1(1), seq1(1));
  endtask

  task automatic test_overflow();
    test_product("overflow", fill(16), fill(16));
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) test_product("random", rnd(), rnd());
  endtask

  // start pulses at edges 5 and 26, operands zeroed at edge 3.
  task automatic test_busy_ignore();
    mat_t a, b, exp_c;
    int   dones, e, done_at;
    a = rnd();
    b = rnd();
    exp_c = model(a, b);
    dones   = 0;
    done_at = -1;
    @(negedge clk);
    bus_if.A     = a;
    bus_if.B     = b;
    bus_if.start = 1'b1;
    for (e = 0; e < 60; e++) begin
      @(negedge clk);
      bus_if.start = (e == 4 || e == 25) ? 1'b1 : 1'b0;
      if (e == 2) begin
        bus_if.A = fill(0);
        bus_if.B = fill(0);
      end
      if (bus_if.done === 1'b1) begin
        dones++;
        done_at = e;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            vectors++;
            if (bus_if.C[i][j] !== exp_c[i][j]) begin
              errors++;
              $display("FAIL busy_C[%0d][%0d] got %0d want %0d", i, j, bus_if.C[i][j], exp_c[i][j]);
            end
          end
      end
    end
    vectors++;
    if (dones !== 1 || done_at !== 27) begin
      errors++;
      $display("FAIL busy_done_pulses got %0d at %0d want 1 at 27", dones, done_at);
    end
    vectors++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle_after got %b want 0", bus_if.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    bus_if.A     = rnd();
    bus_if.B     = rnd();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vectors++;
        if (bus_if.C[i][j] !== 8'd0) begin
          errors++;
          $display("FAIL midreset_C[%0d][%0d] got %0d want 0", i, j, bus_if.C[i][j]);
        end
      end
    test_product("after_reset", rnd(), rnd());
  endtask

  task automatic test_back_to_back();
    mat_t a, b, exp_c;
    logic busy_h [130];
    int   done_t [$];
    int   guard;
    a = rnd();
    b = rnd();
    exp_c = model(a, b);
    @(negedge clk);
    bus_if.A     = a;
    bus_if.B     = b;
    bus_if.start = 1'b1;
    for (int e = 0; e < 130; e++) begin
      @(negedge clk);
      busy_h[e] = bus_if.busy;
      if (bus_if.done === 1'b1) begin
        done_t.push_back(e);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            vectors++;
            if (bus_if.C[i][j] !== exp_c[i][j]) begin
              errors++;
              $display("FAIL b2b_C[%0d][%0d] got %0d want %0d", i, j, bus_if.C[i][j], exp_c[i][j]);
            end
          end
      end
    end
    bus_if.start = 1'b0;
    vectors++;
    if (done_t.size() !== 4 || done_t[0] !== 27) begin
      errors++;
      $display("FAIL b2b_pulse_count got %0d (first at %0d) want 4 (first at 27)",
               done_t.size(), (done_t.size() > 0) ? done_t[0] : -1);
    end
    for (int k = 1; k < done_t.size(); k++) begin
      vectors++;
      if (done_t[k] - done_t[k-1] !== 29) begin
        errors++;
        $display("FAIL b2b_period got %0d want 29", done_t[k] - done_t[k-1]);
      end
      vectors++;
      if (busy_h[done_t[k-1] + 1] !== 1'b0 || busy_h[done_t[k-1] + 2] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_idle_gap busy=%b,%b want 0,1",
                 busy_h[done_t[k-1] + 1], busy_h[done_t[k-1] + 2]);
      end
    end
    guard = 0;
    while (bus_if.busy !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain busy got %b want 0", bus_if.busy);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_general();
    test_overflow();
    test_random();
    test_busy_ignore();
    test_general();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
